// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for the 5-bit sequence detector.
//
// Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock
// on sout. A one-word holding register lets a second word wait while the first shifts,
// so back-to-back words come out with no gap. Between words, sout carries IDLE_BIT, which
// walks the downstream detector back to its start state.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   din        in   parallel word (WIDTH bits)
//   din_valid  in   din is valid this cycle
//   din_ready  out  holding register empty (registered)
//   sout       out  serial bit, feeds detector input x (registered)
//   sout_valid out  sout carries a data bit rather than the idle bit
//   word_done  out  last bit of a word is on sout this cycle
//   busy       out  shifter or holding register occupied
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             din_ready_q, din_ready_d;

  logic             accept;
  logic [WIDTH-1:0] shift_adv;

  assign accept = din_valid & din_ready_q;

  // The bit on sout always sits at the shifter's output end; advancing moves the next
  // bit into that position.
  assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        // Idle accepts bypass the holding register so the first bit appears next cycle.
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = din;
          end else begin
            state_d = StIdle;
          end
        end else begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from next state so they are registered with it.
    sout_valid_d = (state_d == StShift);
    if (state_d == StShift) begin
      sout_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
    end else begin
      sout_d = IDLE_BIT;
    end
    word_done_d = (state_d == StShift) && (cnt_d == CntLast);
    busy_d      = (state_d == StShift) || hold_full_d;
    din_ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      word_done_q  <= word_done_d;
      busy_q       <= busy_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign word_done  = word_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance share stimulus.
// The reference model tracks only the count of data bits still owed and a queue of
// accepted words; every output is predicted from those.
module tb_seq_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;

  logic rdy_m, sout_m, sv_m, done_m, busy_m;
  logic rdy_l, sout_l, sv_l, done_l, busy_l;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .reset(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .word_done(done_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .reset(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .word_done(done_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int           owed = 0;        // data bits still to appear on sout, current one included
  logic [W-1:0] wq[$];           // accepted words not yet fully emitted
  bit           last_acc = 1'b0; // model says the last edge transferred a word

  // Monitor bookkeeping for directed checks
  logic [W-1:0] cap_m = '0, cap_l = '0;
  int           run = 0, last_run = 0, bit_total = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a word is taken whenever at most one word's worth of bits is owed.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        owed     = 0;
        last_acc = 1'b0;
        wq.delete();
      end else begin
        last_acc = din_valid && (owed <= W);
        owed     = ((owed > 0) ? owed - 1 : 0) + (last_acc ? W : 0);
        if (last_acc) wq.push_back(din);
      end
    end
  end

  // Monitor: compare both DUTs against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic         exp_v, exp_done, exp_rdy, eb_m, eb_l;
        int           c;
        logic [W-1:0] w;
        exp_v    = (owed > 0);
        exp_rdy  = (owed <= W);
        exp_done = exp_v && ((owed % W) == 1);
        c        = (W - (owed % W)) % W;
        eb_m     = 1'b1;
        eb_l     = 1'b1;
        if (exp_v) begin
          if (wq.size() == 0) begin
            chk("scoreboard_nonempty", 1'b0, 1'b1);
          end else begin
            w    = wq[0];
            eb_m = w[W-1-c];
            eb_l = w[c];
          end
        end
        chk("din_ready_m", rdy_m, exp_rdy);
        chk("din_ready_l", rdy_l, exp_rdy);
        chk("sout_valid_m", sv_m, exp_v);
        chk("sout_valid_l", sv_l, exp_v);
        chk("busy_m", busy_m, exp_v);
        chk("busy_l", busy_l, exp_v);
        chk("word_done_m", done_m, exp_done);
        chk("word_done_l", done_l, exp_done);
        chk("sout_m", sout_m, eb_m);
        chk("sout_l", sout_l, eb_l);
        if (exp_done && wq.size() > 0) void'(wq.pop_front());

        if (sv_m) begin
          cap_m = {cap_m[W-2:0], sout_m};
          cap_l = {cap_l[W-2:0], sout_l};
          run++;
          bit_total++;
        end else begin
          if (run > 0) last_run = run;
          run = 0;
        end
      end
    end
  end

  // Present a word and hold it until the model sees it taken, then scramble din.
  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok        = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (last_acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    din_valid = 1'b0;
    din       = W'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    #12;
    rst_n = 1'b1;

    // Idle after reset
    idle_cycles(20);
    chk("idle_sout", sout_m, 1'b1);
    chk_int("idle_bits", bit_total, 0);

    // Single word, both bit orders
    send(8'b0110_1000);
    idle_cycles(10);
    chk_int("single_msb_bits", int'(cap_m), int'(8'b0110_1000));
    chk_int("single_run", last_run, 8);

    send(8'b0001_0110);
    idle_cycles(10);
    chk_int("lsb_first_bits", int'(cap_l), int'(8'b0110_1000));

    // Back-to-back
    send(8'hA5);
    send(8'h3C);
    idle_cycles(20);
    chk_int("b2b_run", last_run, 16);
    chk_int("b2b_second_word", int'(cap_m), int'(8'h3C));

    // Backpressure: valid held high across five words of 8'hFF
    bit_total = 0;
    for (int i = 0; i < 5; i++) send(8'hFF);
    idle_cycles(25);
    chk_int("bp_bits", bit_total, 40);
    chk_int("bp_run", last_run, 40);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 12));
      else send(W'($urandom));
    end
    idle_cycles(25);
    chk_int("rand_drained", wq.size(), 0);

    // Reset in the middle of a word with a second word held
    send(8'h5A);
    send(8'hC3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sout_m", sout_m, 1'b1);
    chk("rst_sout_l", sout_l, 1'b1);
    chk("rst_valid_m", sv_m, 1'b0);
    chk("rst_ready_m", rdy_m, 1'b1);
    chk("rst_busy_m", busy_m, 1'b0);
    chk("rst_done_l", done_l, 1'b0);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    bit_total = 0;
    idle_cycles(20);
    chk_int("post_rst_bits", bit_total, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
